// File: rtl/song_sequencer_pkg.sv
// rtl/song_sequencer_pkg.sv - shared song entry layout, state encoding and note helper
package song_sequencer_pkg;

    localparam int NOTE_MSB = 7;
    localparam int NOTE_LSB = 3;
    localparam int LEN_MSB  = 2;
    localparam int LEN_LSB  = 0;

    localparam logic [2:0] END_LEN          = 3'd0;
    localparam int         MAX_NOTE_DEFAULT = 21;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        PLAY,
        GAP
    } seq_state_t;

    // Out-of-range note indices play as a rest.
    function automatic logic [4:0] clamp_note(input logic [4:0] n, input logic [4:0] max_note);
        return (n > max_note) ? 5'd0 : n;
    endfunction

endpackage

// File: rtl/song_sequencer_if.sv
// rtl/song_sequencer_if.sv - control, song ROM and buzzer note signals of the sequencer
interface song_sequencer_if #(
    parameter int ADDR_W = 8
);
    logic              mode;
    logic [4:0]        key_note;
    logic              start;
    logic              stop;
    logic              pause;
    logic              loop_en;
    logic [ADDR_W-1:0] rom_addr;
    logic [7:0]        rom_data;
    logic [4:0]        note;
    logic              busy;
    logic              done;

    modport master (
        output mode, key_note, start, stop, pause, loop_en, rom_data,
        input  rom_addr, note, busy, done
    );

    modport slave (
        input  mode, key_note, start, stop, pause, loop_en, rom_data,
        output rom_addr, note, busy, done
    );
endinterface

// File: rtl/song_sequencer_beat_timer.sv
// rtl/song_sequencer_beat_timer.sv - beat and beats-remaining counters for one song entry
module song_sequencer_beat_timer #(
    parameter int BEAT_CYCLES = 25_000_000,
    parameter int GAP_CYCLES  = 2_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [2:0] length,
    input  logic       enable,
    output logic       play_end,
    output logic       gap_end
);
    localparam logic [31:0] BEAT_LAST = 32'(BEAT_CYCLES - 1);
    localparam logic [31:0] PLAY_LAST = 32'(BEAT_CYCLES - GAP_CYCLES - 1);

    logic [31:0] beat_cnt;
    logic [2:0]  beats_left;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt   <= '0;
            beats_left <= '0;
        end else if (load) begin
            beat_cnt   <= '0;
            beats_left <= length;
        end else if (enable) begin
            if (beat_cnt == BEAT_LAST) begin
                beat_cnt   <= '0;
                beats_left <= beats_left - 3'd1;
            end else begin
                beat_cnt <= beat_cnt + 32'd1;
            end
        end
    end

    // The gap is the tail of the last beat, so one counter covers both phases.
    assign play_end = enable && (beats_left == 3'd1) && (beat_cnt == PLAY_LAST);
    assign gap_end  = enable && (beats_left == 3'd1) && (beat_cnt == BEAT_LAST);

endmodule

// File: rtl/song_sequencer.sv
// rtl/song_sequencer.sv - free-play passthrough and ROM-driven auto-play of buzzer notes
module song_sequencer
    import song_sequencer_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int BEAT_CYCLES = 25_000_000,
    parameter int GAP_CYCLES  = 2_000_000,
    parameter int MAX_NOTE    = MAX_NOTE_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    song_sequencer_if.slave  bus
);
    localparam logic [4:0] NOTE_LIMIT = 5'(MAX_NOTE);

    seq_state_t        state;
    logic [ADDR_W-1:0] rom_addr;
    logic [4:0]        note;
    logic [4:0]        entry_note;
    logic              busy;
    logic              done;
    logic              play_end;
    logic              gap_end;
    logic              timer_enable;
    logic [2:0]        entry_len;
    logic [4:0]        entry_pitch;

    assign entry_len    = bus.rom_data[LEN_MSB:LEN_LSB];
    assign entry_pitch  = bus.rom_data[NOTE_MSB:NOTE_LSB];
    assign timer_enable = ((state == PLAY) || (state == GAP)) && !bus.pause;

    song_sequencer_beat_timer #(
        .BEAT_CYCLES (BEAT_CYCLES),
        .GAP_CYCLES  (GAP_CYCLES)
    ) u_beat_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (state == LOAD),
        .length   (entry_len),
        .enable   (timer_enable),
        .play_end (play_end),
        .gap_end  (gap_end)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rom_addr   <= '0;
            note       <= '0;
            entry_note <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (!bus.mode) begin
                state    <= IDLE;
                busy     <= 1'b0;
                rom_addr <= '0;
                note     <= clamp_note(bus.key_note, NOTE_LIMIT);
            end else if (bus.stop) begin
                state    <= IDLE;
                busy     <= 1'b0;
                rom_addr <= '0;
                note     <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        note <= '0;
                        if (bus.start) begin
                            rom_addr <= '0;
                            busy     <= 1'b1;
                            state    <= FETCH;
                        end
                    end
                    FETCH: begin
                        note  <= '0;
                        state <= LOAD;
                    end
                    LOAD: begin
                        if (entry_len == END_LEN) begin
                            note     <= '0;
                            rom_addr <= '0;
                            if (bus.loop_en) begin
                                state <= FETCH;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end else begin
                            entry_note <= clamp_note(entry_pitch, NOTE_LIMIT);
                            note       <= clamp_note(entry_pitch, NOTE_LIMIT);
                            state      <= PLAY;
                        end
                    end
                    PLAY: begin
                        // A paused note is silenced; entry_note restores it on release.
                        if (bus.pause || play_end) begin
                            note <= '0;
                        end else begin
                            note <= entry_note;
                        end
                        if (play_end) begin
                            state <= GAP;
                        end
                    end
                    GAP: begin
                        note <= '0;
                        if (gap_end) begin
                            rom_addr <= rom_addr + ADDR_W'(1);
                            state    <= FETCH;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        note  <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.rom_addr = rom_addr;
    assign bus.note     = note;
    assign bus.busy     = busy;
    assign bus.done     = done;

endmodule
